// File: rtl/pong_game_ctrl.sv
// ---------------------------------------------------------------------------
// pong_game_ctrl: game-state sequencer (score, balls, winner, overlay mask)
// Optional: PONG_CTRL_SERVE_HOLD_EN -- NEWBALL also waits for a start press.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module pong_game_ctrl #(
  parameter int BALLS       = 9,
  parameter int WIN_SCORE   = 5,
  parameter int TIMER_TICKS = 120
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] btn,
  input  logic       frame_tick,
  input  logic       miss_left,
  input  logic       miss_right,
  output logic       graph_still,
  output logic [3:0] ball,
  output logic [3:0] left_score,
  output logic [3:0] right_score,
  output logic       winner,
  output logic       serve_dir,
  output logic [3:0] text_mask,
  output logic [1:0] state_o
);

  localparam logic [1:0] NEWGAME = 2'b00;
  localparam logic [1:0] PLAY    = 2'b01;
  localparam logic [1:0] NEWBALL = 2'b10;
  localparam logic [1:0] OVER    = 2'b11;

  localparam logic [3:0] BALLS_INIT = 4'(BALLS);
  localparam logic [3:0] WIN_VAL    = 4'(WIN_SCORE);
  localparam logic [7:0] TICKS_INIT = 8'(TIMER_TICKS);

  logic [1:0] state, state_n;
  logic [7:0] timer;
  logic       btn_q;
  logic       start, done;
  logic [3:0] ball_n, ls_n, rs_n;
  logic [3:0] ls_inc, rs_inc, ball_dec;
  logic       winner_n, serve_n;
  logic       still_n;
  logic [3:0] mask_n;
  logic       only_right, only_left;

  assign start      = (|btn) & ~btn_q;
  assign done       = (timer == 8'd0);
  assign ls_inc     = (left_score  == 4'd9) ? 4'd9 : left_score  + 4'd1;
  assign rs_inc     = (right_score == 4'd9) ? 4'd9 : right_score + 4'd1;
  assign ball_dec   = (ball == 4'd0) ? 4'd0 : ball - 4'd1;
  assign only_right = miss_right & ~miss_left;
  assign only_left  = miss_left & ~miss_right;
  assign state_o    = state;

  always_comb begin
    state_n  = state;
    ball_n   = ball;
    ls_n     = left_score;
    rs_n     = right_score;
    winner_n = winner;
    serve_n  = serve_dir;
    case (state)
      NEWGAME: begin
        if (start) begin
          state_n  = PLAY;
          ball_n   = BALLS_INIT;
          ls_n     = 4'd0;
          rs_n     = 4'd0;
          winner_n = 1'b0;
        end
      end
      PLAY: begin
        if (miss_left || miss_right) begin
          ball_n = ball_dec;
          if (only_right) begin
            ls_n    = ls_inc;
            serve_n = 1'b1;
          end else if (only_left) begin
            rs_n    = rs_inc;
            serve_n = 1'b0;
          end
          // A winning score ends the game even when the last ball is also spent.
          if (only_right && ls_inc == WIN_VAL) begin
            state_n  = OVER;
            winner_n = 1'b0;
          end else if (only_left && rs_inc == WIN_VAL) begin
            state_n  = OVER;
            winner_n = 1'b1;
          end else if (ball_dec == 4'd0) begin
            state_n = OVER;
            if (ls_n > rs_n)      winner_n = 1'b0;
            else if (rs_n > ls_n) winner_n = 1'b1;
            else                  winner_n = only_left;
          end else begin
            state_n = NEWBALL;
          end
        end
      end
      NEWBALL: begin
`ifdef PONG_CTRL_SERVE_HOLD_EN
        if (done && start) state_n = PLAY;
`else
        if (done) state_n = PLAY;
`endif
      end
      OVER: begin
        if (done) state_n = NEWGAME;
      end
      default: state_n = NEWGAME;
    endcase
  end

  always_comb begin
    still_n = 1'b1;
    mask_n  = 4'b1110;
    case (state_n)
      NEWGAME: begin still_n = 1'b1; mask_n = 4'b1110; end
      PLAY:    begin still_n = 1'b0; mask_n = 4'b1000; end
      NEWBALL: begin still_n = 1'b1; mask_n = 4'b1000; end
      OVER:    begin still_n = 1'b1; mask_n = 4'b1001; end
      default: begin still_n = 1'b1; mask_n = 4'b1110; end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= NEWGAME;
      ball        <= BALLS_INIT;
      left_score  <= 4'd0;
      right_score <= 4'd0;
      winner      <= 1'b0;
      serve_dir   <= 1'b0;
      graph_still <= 1'b1;
      text_mask   <= 4'b1110;
      timer       <= 8'd0;
      btn_q       <= 1'b0;
    end else begin
      state       <= state_n;
      ball        <= ball_n;
      left_score  <= ls_n;
      right_score <= rs_n;
      winner      <= winner_n;
      serve_dir   <= serve_n;
      graph_still <= still_n;
      text_mask   <= mask_n;
      btn_q       <= |btn;
      // Load on entry takes precedence over a coincident frame tick.
      if ((state_n != state) && (state_n == NEWBALL || state_n == OVER))
        timer <= TICKS_INIT;
      else if (frame_tick && timer != 8'd0)
        timer <= timer - 8'd1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pong_game_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pong_game_ctrl: scoreboard bench for pong_game_ctrl (default parameters)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_pong_game_ctrl;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic [1:0] btn = 2'b00;
  logic       frame_tick = 1'b0;
  logic       miss_left = 1'b0;
  logic       miss_right = 1'b0;
  logic       graph_still;
  logic [3:0] ball, left_score, right_score, text_mask;
  logic       winner, serve_dir;
  logic [1:0] state_o;

  int errors = 0;
  int checks = 0;
  logic [20:0] exp_q[$];
  logic [20:0] got, exp_v;

  pong_game_ctrl dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .btn         (btn),
    .frame_tick  (frame_tick),
    .miss_left   (miss_left),
    .miss_right  (miss_right),
    .graph_still (graph_still),
    .ball        (ball),
    .left_score  (left_score),
    .right_score (right_score),
    .winner      (winner),
    .serve_dir   (serve_dir),
    .text_mask   (text_mask),
    .state_o     (state_o)
  );

  always #5 clk = ~clk;

  // Packed view: {state, ball, left, right, winner, serve, still, mask}
  function automatic logic [20:0] mk(input logic [1:0] st, input int b, input int l, input int r,
                                     input logic w, input logic s, input logic g, input logic [3:0] m);
    return {st, 4'(b), 4'(l), 4'(r), w, s, g, m};
  endfunction

  function automatic logic [20:0] snap();
    return {state_o, ball, left_score, right_score, winner, serve_dir, graph_still, text_mask};
  endfunction

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic frames(input int n);
    frame_tick = 1'b1;
    cyc(n);
    frame_tick = 1'b0;
  endtask

  task automatic miss(input logic l, input logic r);
    miss_left = l; miss_right = r;
    cyc(1);
    miss_left = 1'b0; miss_right = 1'b0;
  endtask

  task automatic press();
    btn = 2'b01;
    cyc(1);
    btn = 2'b00;
    cyc(1);
  endtask

  task automatic serve_wait();
    frames(120);
`ifdef PONG_CTRL_SERVE_HOLD_EN
    press();
`else
    cyc(1);
`endif
  endtask

  task automatic test_reset();
    #2 reset_n = 1'b0;
    #1;
    checks++; got = snap(); exp_v = mk(2'b00, 9, 0, 0, 0, 0, 1, 4'b1110);
    if (got !== exp_v) begin errors++; $display("FAIL reset_init got=%h exp=%h", got, exp_v); end
    cyc(2);
    reset_n = 1'b1;
    cyc(2);
    checks++; got = snap();
    if (got !== exp_v) begin errors++; $display("FAIL reset_idle got=%h exp=%h", got, exp_v); end
  endtask

  task automatic test_start();
    btn = 2'b01;
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      checks++; got = snap(); exp_v = mk(2'b01, 9, 0, 0, 0, 0, 0, 4'b1000);
      if (got !== exp_v) begin errors++; $display("FAIL start_hold cycle=%0d got=%h exp=%h", i, got, exp_v); end
    end
    btn = 2'b00;
    cyc(1);
  endtask

  task automatic test_miss_right();
    exp_q.push_back(mk(2'b10, 8, 1, 0, 0, 1, 1, 4'b1000));
    miss(1'b0, 1'b1);
    got = snap(); exp_v = exp_q.pop_front(); checks++;
    if (got !== exp_v) begin errors++; $display("FAIL miss_right got=%h exp=%h", got, exp_v); end
    frames(120);
    checks++;
    if (state_o !== 2'b10) begin errors++; $display("FAIL newball_timer_hold got=%b exp=10", state_o); end
`ifdef PONG_CTRL_SERVE_HOLD_EN
    cyc(2);
    checks++;
    if (state_o !== 2'b10) begin errors++; $display("FAIL serve_hold_no_btn got=%b exp=10", state_o); end
    press();
`else
    cyc(1);
`endif
    checks++; got = snap(); exp_v = mk(2'b01, 8, 1, 0, 0, 1, 0, 4'b1000);
    if (got !== exp_v) begin errors++; $display("FAIL newball_return got=%h exp=%h", got, exp_v); end
  endtask

  task automatic test_both_miss();
    exp_q.push_back(mk(2'b10, 7, 1, 0, 0, 1, 1, 4'b1000));
    miss(1'b1, 1'b1);
    got = snap(); exp_v = exp_q.pop_front(); checks++;
    if (got !== exp_v) begin errors++; $display("FAIL both_miss got=%h exp=%h", got, exp_v); end
    miss(1'b1, 1'b0);
    got = snap(); checks++;
    if (got !== exp_v) begin errors++; $display("FAIL miss_in_newball got=%h exp=%h", got, exp_v); end
    serve_wait();
    exp_q.push_back(mk(2'b10, 6, 1, 1, 0, 0, 1, 4'b1000));
    miss(1'b1, 1'b0);
    got = snap(); exp_v = exp_q.pop_front(); checks++;
    if (got !== exp_v) begin errors++; $display("FAIL miss_left got=%h exp=%h", got, exp_v); end
    serve_wait();
  endtask

  task automatic test_reset_midgame();
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(mk(2'b10, 5 - i, 2 + i, 1, 0, 1, 1, 4'b1000));
      miss(1'b0, 1'b1);
      got = snap(); exp_v = exp_q.pop_front(); checks++;
      if (got !== exp_v) begin errors++; $display("FAIL pre_reset_miss i=%0d got=%h exp=%h", i, got, exp_v); end
      serve_wait();
    end
    checks++; got = snap(); exp_v = mk(2'b01, 4, 3, 1, 0, 1, 0, 4'b1000);
    if (got !== exp_v) begin errors++; $display("FAIL midgame_play got=%h exp=%h", got, exp_v); end
    #2 reset_n = 1'b0;
    #1;
    checks++; got = snap(); exp_v = mk(2'b00, 9, 0, 0, 0, 0, 1, 4'b1110);
    if (got !== exp_v) begin errors++; $display("FAIL async_reset got=%h exp=%h", got, exp_v); end
    cyc(1);
    reset_n = 1'b1;
    cyc(1);
    checks++; got = snap();
    if (got !== exp_v) begin errors++; $display("FAIL post_reset got=%h exp=%h", got, exp_v); end
  endtask

  task automatic test_win();
    int lc, rc;
    logic r;
    lc = 0; rc = 0;
    press();
    checks++; got = snap(); exp_v = mk(2'b01, 9, 0, 0, 0, 0, 0, 4'b1000);
    if (got !== exp_v) begin errors++; $display("FAIL win_game_start got=%h exp=%h", got, exp_v); end
    for (int i = 0; i < 8; i++) begin
      r = (i % 2 == 1);
      if (r) lc++; else rc++;
      exp_q.push_back(mk(2'b10, 8 - i, lc, rc, 0, r, 1, 4'b1000));
      miss(~r, r);
      got = snap(); exp_v = exp_q.pop_front(); checks++;
      if (got !== exp_v) begin errors++; $display("FAIL rally i=%0d got=%h exp=%h", i, got, exp_v); end
      serve_wait();
    end
    exp_q.push_back(mk(2'b11, 0, 5, 4, 0, 1, 1, 4'b1001));
    miss(1'b0, 1'b1);
    got = snap(); exp_v = exp_q.pop_front(); checks++;
    if (got !== exp_v) begin errors++; $display("FAIL win_score got=%h exp=%h", got, exp_v); end
    press();
    checks++;
    if (state_o !== 2'b11) begin errors++; $display("FAIL start_in_over got=%b exp=11", state_o); end
    frames(120);
    checks++;
    if (state_o !== 2'b11) begin errors++; $display("FAIL over_timer_hold got=%b exp=11", state_o); end
    cyc(1);
    checks++; got = snap(); exp_v = mk(2'b00, 0, 5, 4, 0, 1, 1, 4'b1110);
    if (got !== exp_v) begin errors++; $display("FAIL over_to_newgame got=%h exp=%h", got, exp_v); end
    press();
    checks++; got = snap(); exp_v = mk(2'b01, 9, 0, 0, 0, 1, 0, 4'b1000);
    if (got !== exp_v) begin errors++; $display("FAIL restart got=%h exp=%h", got, exp_v); end
  endtask

  task automatic test_ball_exhaust_tie();
    for (int i = 0; i < 7; i++) begin
      exp_q.push_back(mk(2'b10, 8 - i, 0, 0, 0, 1, 1, 4'b1000));
      miss(1'b1, 1'b1);
      got = snap(); exp_v = exp_q.pop_front(); checks++;
      if (got !== exp_v) begin errors++; $display("FAIL tie_simul i=%0d got=%h exp=%h", i, got, exp_v); end
      serve_wait();
    end
    exp_q.push_back(mk(2'b10, 1, 0, 1, 0, 0, 1, 4'b1000));
    miss(1'b1, 1'b0);
    got = snap(); exp_v = exp_q.pop_front(); checks++;
    if (got !== exp_v) begin errors++; $display("FAIL tie_left got=%h exp=%h", got, exp_v); end
    serve_wait();
    exp_q.push_back(mk(2'b11, 0, 1, 1, 0, 1, 1, 4'b1001));
    miss(1'b0, 1'b1);
    got = snap(); exp_v = exp_q.pop_front(); checks++;
    if (got !== exp_v) begin errors++; $display("FAIL tie_last_scorer got=%h exp=%h", got, exp_v); end
    frames(120);
    cyc(1);
    press();
  endtask

  task automatic test_winner_right();
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(mk(2'b10, 8 - i, 0, 0, 0, 1, 1, 4'b1000));
      frame_tick = 1'b1;
      miss(1'b1, 1'b1);
      frame_tick = 1'b0;
      got = snap(); exp_v = exp_q.pop_front(); checks++;
      if (got !== exp_v) begin errors++; $display("FAIL wr_simul i=%0d got=%h exp=%h", i, got, exp_v); end
      if (i == 0) begin
        frames(120);
        checks++;
        if (state_o !== 2'b10) begin errors++; $display("FAIL load_beats_tick got=%b exp=10", state_o); end
`ifdef PONG_CTRL_SERVE_HOLD_EN
        press();
`else
        cyc(1);
`endif
      end else begin
        serve_wait();
      end
    end
    exp_q.push_back(mk(2'b11, 0, 0, 1, 1, 0, 1, 4'b1001));
    miss(1'b1, 1'b0);
    got = snap(); exp_v = exp_q.pop_front(); checks++;
    if (got !== exp_v) begin errors++; $display("FAIL winner_right got=%h exp=%h", got, exp_v); end
  endtask

  initial begin
    test_reset();
    test_start();
    test_miss_right();
    test_both_miss();
    test_reset_midgame();
    test_win();
    test_ball_exhaust_tie();
    test_winner_right();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/pong_game_ctrl.md
Name: pong_game_ctrl

Overview:
- Game-state sequencer for the 2-player pong display.
- Owns the score, ball and winner registers that feed the text overlay, and freezes or releases the graphics engine.
- Produces a 4-bit overlay mask that the top level ANDs with the text generator's {score, logo, rule, over} region flags.
- Sits between the graphics engine (miss events, frame tick), the buttons, and the text overlay.

Parameters:
- BALLS, 9: balls per game, 1..9; loaded into ball at game start.
- WIN_SCORE, 5: score that ends the game immediately, 1..9.
- TIMER_TICKS, 120: frame ticks of pause in NEWBALL and OVER, 1..255 (2 s at 60 Hz).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- btn  in  2  player buttons, level, already synchronised; any bit high = "start"
- frame_tick  in  1  one-cycle pulse per video frame
- miss_left  in  1  one-cycle pulse: ball left the left edge (right player scores)
- miss_right  in  1  one-cycle pulse: ball left the right edge (left player scores)
- graph_still  out  1  1 = graphics held (ball parked), 0 = ball moving
- ball  out  4  balls remaining, binary 0..9
- left_score  out  4  binary 0..9
- right_score  out  4  binary 0..9
- winner  out  1  0 = left/Blue, 1 = right/Red; valid in OVER
- serve_dir  out  1  next serve direction, 0 = toward left, 1 = toward right
- text_mask  out  4  {score_en, logo_en, rule_en, over_en}
- state_o  out  2  00 NEWGAME, 01 PLAY, 10 NEWBALL, 11 OVER (debug)

Behaviour:
- Interface: one clock, clk; reset_n is asynchronous and active-low.
- All outputs are registered; there are no combinational input-to-output paths.
- Reset values: state NEWGAME, ball=BALLS, scores 0, winner 0, serve_dir 0, graph_still 1, text_mask 1110, timer 0, btn_q 0.
- Start detection: btn_q registers |btn; start = |btn & ~btn_q.
- Timer: 8-bit down-counter, loaded with TIMER_TICKS on entry to NEWBALL or OVER.
  - Decrements on frame_tick while nonzero.
  - done = (timer==0), evaluated in the cycle after the last decrement.
- NEWGAME: graph_still=1, text_mask=1110. On start: go to PLAY and load scores=0, ball=BALLS, winner=0.
- PLAY: graph_still=0, text_mask=1000. Misses are evaluated in priority order:
  - miss_right alone: left_score+1, ball-1, serve_dir=1 (serve toward the loser).
  - miss_left alone: right_score+1, ball-1, serve_dir=0.
  - Both in the same cycle: no score change, ball-1, serve_dir unchanged.
  - After any miss, decide the next state from the updated values:
    - If the scorer's new score == WIN_SCORE: go to OVER, winner = scorer.
    - Else if the new ball == 0: go to OVER, winner = higher score. A tie goes to the last scorer; a simultaneous-miss tie keeps winner at 0.
    - Otherwise go to NEWBALL.
  - Neither miss: stay in PLAY.
- NEWBALL: graph_still=1, text_mask=1000. On done: go to PLAY.
- OVER: graph_still=1, text_mask=1001. On done: go to NEWGAME. Scores and winner are held until the next start.
- Misses outside PLAY are ignored. Start outside NEWGAME is ignored (except as defined under Optional Feature).
- Arithmetic:
  - Scores saturate at 9; ball saturates at 0.
  - ball never decrements below 0 even if a miss arrives in the cycle ball becomes 0, because the FSM has already left PLAY.
- Reset mid-game returns to the reset values asynchronously. The first clock after release acts as NEWGAME.
- frame_tick coincident with timer load: the load wins.

Optional Feature:
- Macro: PONG_CTRL_SERVE_HOLD_EN.
- Defined: NEWBALL leaves for PLAY only when done is true and a start edge occurs. A start edge before done is discarded; after done, the bench must press again.
- Undefined: NEWBALL leaves for PLAY on done alone; buttons are ignored.

Test Plan:
- Reset with reset_n=0 mid-PLAY (left_score=3), then release → state_o=00, scores 0, ball=9, graph_still=1, text_mask=1110 immediately, without a clock edge.
- NEWGAME, btn=01 held 5 cycles → exactly one transition to PLAY, one clock after the rising sample; graph_still=0, text_mask=1000.
- PLAY, pulse miss_right → next cycle left_score=1, ball=8, serve_dir=1, state NEWBALL. After 120 frame_tick pulses, state returns to PLAY. With SERVE_HOLD_EN, it also needs a btn edge.
- PLAY, left_score=4 (WIN_SCORE=5), pulse miss_right → OVER, winner=0, text_mask=1001. After 120 frame_ticks → NEWGAME with scores still 5:4. A start edge → scores 0:0, ball=9.
- BALLS=2: miss_left, then miss_right → ball=0, scores 1:1, tie → winner=0 (last scorer left), state OVER.
- PLAY, miss_left and miss_right in the same cycle → scores unchanged, ball decremented by 1, state NEWBALL. A miss pulse during NEWBALL → no change.
